// File: rtl/uart_pkg.sv
// uart_pkg: shared register offsets, LSR bit positions and FSM state
// encodings for the 8N1 UART peripheral (uart_module / uart_rx).
package uart_pkg;

    // Register offsets within the 8-byte window
    localparam logic [2:0] OFF_THR_RBR = 3'd0;
    localparam logic [2:0] OFF_LSR     = 3'd5;

    // Line status register bit positions
    localparam int unsigned LSR_DR   = 0;
    localparam int unsigned LSR_OE   = 1;
    localparam int unsigned LSR_FE   = 3;
    localparam int unsigned LSR_THRE = 5;
    localparam int unsigned LSR_TEMT = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [7:0] lsr_pack(input logic dr, input logic oe,
                                            input logic fe, input logic thre,
                                            input logic temt);
        logic [7:0] v;
        v           = '0;
        v[LSR_DR]   = dr;
        v[LSR_OE]   = oe;
        v[LSR_FE]   = fe;
        v[LSR_THRE] = thre;
        v[LSR_TEMT] = temt;
        return v;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchroniser.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_rxd            asynchronous serial input, idle high
//   o_valid          one-cycle pulse at the stop-bit midpoint
//   o_byte           received byte (valid with o_valid)
//   o_frame_err      stop bit sampled low (valid with o_valid)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxd,
    output logic       o_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1, r_sync2, r_prev;
    rx_state_t        r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_full, w_half;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_full = (r_cnt == CNT_FULL);
    assign w_half = (r_cnt == CNT_HALF);

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (r_prev && !r_sync2) w_next = RX_START;
            // line back high at mid start bit means the edge was a glitch
            RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && r_bit == 3'd7) w_next = RX_STOP;
            RX_STOP:  if (w_full) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            // counter restarts on every state change and on each bit boundary,
            // so after the half-bit start check every sample lands mid-bit
            if (r_state == RX_IDLE || w_next != r_state || w_full)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == RX_START) begin
                r_bit <= '0;
            end else if (r_state == RX_DATA && w_full) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_sync2, r_shift[7:1]};
            end
        end
    end

    assign o_valid     = (r_state == RX_STOP) && w_full;
    assign o_byte      = r_shift;
    assign o_frame_err = ~r_sync2;

endmodule

// File: rtl/uart_module.sv
// uart_module: memory-mapped 8N1 UART (16550-style THR/RBR at +0, LSR at +5).
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   addr           byte address, decoded relative to BASE_ADDR
//   data           bidirectional bus; driven only during read responses
//   we, req_valid  request strobe and direction (1 = write)
//   data_valid     one-cycle acknowledge / read-response pulse
//   txd, rxd       serial lines, idle high
module uart_module
    import uart_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH   = 32,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned            CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  we,
    input  logic                  req_valid,
    output logic                  data_valid,
    output logic                  txd,
    input  logic                  rxd
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    // ---------------- bus decode ----------------
    logic [ADDR_WIDTH-1:0] w_off;
    logic w_hit, w_sel_thr, w_sel_lsr;
    logic w_rbr_read, w_lsr_read, w_thr_write, w_tx_load;
    logic w_unused_data;
    logic [7:0] w_lsr;

    assign w_off         = addr - BASE_ADDR;
    assign w_hit         = (w_off[ADDR_WIDTH-1:3] == '0);
    assign w_sel_thr     = w_hit && (w_off[2:0] == OFF_THR_RBR);
    assign w_sel_lsr     = w_hit && (w_off[2:0] == OFF_LSR);
    assign w_rbr_read    = req_valid && !we && w_sel_thr;
    assign w_lsr_read    = req_valid && !we && w_sel_lsr;
    assign w_unused_data = ^data[DATA_WIDTH-1:8];

    // ---------------- receive path ----------------
    logic       w_rx_valid, w_rx_ferr;
    logic [7:0] w_rx_byte;
    logic [7:0] r_rbr;
    logic       r_dr, r_oe, r_fe;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_rxd      (rxd),
        .o_valid    (w_rx_valid),
        .o_byte     (w_rx_byte),
        .o_frame_err(w_rx_ferr)
    );

    // a new byte landing wins over a same-cycle read clearing the flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rbr <= '0;
            r_dr  <= 1'b0;
            r_oe  <= 1'b0;
            r_fe  <= 1'b0;
        end else begin
            if (w_rx_valid) r_rbr <= w_rx_byte;
            r_dr <= w_rx_valid | (r_dr & ~w_rbr_read);
            r_oe <= (w_rx_valid & r_dr) | (r_oe & ~w_lsr_read);
            r_fe <= (w_rx_valid & w_rx_ferr) | (r_fe & ~w_lsr_read);
        end
    end

    // ---------------- transmit path ----------------
    tx_state_t        r_tx_state, w_tx_next;
    logic [7:0]       r_thr, r_tx_shift;
    logic             r_thre, r_txd, w_txd_next, w_tx_full;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;

    assign w_tx_full = (r_tx_cnt == CNT_FULL);
    // the holding register is free either when empty or when it is being
    // moved into the shifter this very cycle, so back-to-back writes queue
    assign w_thr_write = req_valid && we && w_sel_thr && (r_thre || w_tx_load);

    always_comb begin
        w_tx_next  = r_tx_state;
        w_tx_load  = 1'b0;
        case (r_tx_state)
            TX_IDLE:  if (!r_thre) begin
                          w_tx_next = TX_START;
                          w_tx_load = 1'b1;
                      end
            TX_START: if (w_tx_full) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_full && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_full) begin
                          if (!r_thre) begin
                              w_tx_next = TX_START;
                              w_tx_load = 1'b1;
                          end else begin
                              w_tx_next = TX_IDLE;
                          end
                      end
            default:  w_tx_next = TX_IDLE;
        endcase
        // registered line level for the coming cycle
        case (w_tx_next)
            TX_START: w_txd_next = 1'b0;
            TX_DATA:  w_txd_next = (r_tx_state == TX_DATA && w_tx_full) ?
                                   r_tx_shift[1] : r_tx_shift[0];
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_thr      <= '0;
            r_thre     <= 1'b1;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_txd      <= w_txd_next;
            if (w_thr_write) begin
                r_thr  <= data[7:0];
                r_thre <= 1'b0;
            end else if (w_tx_load) begin
                r_thre <= 1'b1;
            end
            if (w_tx_load) begin
                r_tx_shift <= r_thr;
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_full) begin
                    r_tx_cnt <= '0;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
        end
    end

    assign txd   = r_txd;
    assign w_lsr = lsr_pack(r_dr, r_oe, r_fe, r_thre,
                            r_thre && (r_tx_state == TX_IDLE));

    // ---------------- response ----------------
    logic       r_dv, r_drive;
    logic [7:0] r_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dv    <= 1'b0;
            r_drive <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_dv    <= req_valid;
            r_drive <= req_valid && !we;
            r_rdata <= w_rbr_read ? r_rbr : (w_lsr_read ? w_lsr : 8'h00);
        end
    end

    assign data_valid = r_dv;
    assign data       = r_drive ? {{(DATA_WIDTH-8){1'b0}}, r_rdata} : 'z;

endmodule

// File: tb/tb_uart_module.sv
module tb_uart_module;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk, reset, we, req_valid, rxd, tb_drv;
    logic [31:0] addr, tb_wdata, rd;
    wire  [31:0] data;
    logic        data_valid, txd;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          waited, zeros;

    assign data = tb_drv ? tb_wdata : 'z;

    uart_module #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .BASE_ADDR   (32'h1000_0000),
        .CLKS_PER_BIT(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .data      (data),
        .we        (we),
        .req_valid (req_valid),
        .data_valid(data_valid),
        .txd       (txd),
        .rxd       (rxd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one request; returns the bus value seen during the response cycle
    task automatic bus(input string tag, input logic w, input logic [31:0] a,
                       input logic [7:0] wd, output logic [31:0] r);
        @(negedge clk);
        addr = a; we = w; req_valid = 1'b1; tb_wdata = {24'h0, wd}; tb_drv = w;
        @(negedge clk);
        req_valid = 1'b0; we = 1'b0; tb_drv = 1'b0;
        #1;
        check({tag, " dv"}, 32'(data_valid), 32'd1);
        r = data;
        @(negedge clk);
        check({tag, " dv low"}, 32'(data_valid), 32'd0);
    endtask

    task automatic tx_frame(input string tag, input logic [7:0] b, input bit find,
                            output int w);
        w = 0;
        if (find) begin
            while (txd !== 1'b0 && w < 64) begin
                @(negedge clk);
                w++;
            end
            repeat (8) @(negedge clk);
        end else begin
            repeat (16) @(negedge clk);
        end
        check({tag, " start"}, 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            check($sformatf("%s bit%0d", tag, i), 32'(txd), 32'(b[i]));
        end
        repeat (16) @(negedge clk);
        check({tag, " stop"}, 32'(txd), 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(negedge clk);
        end
        rxd = stopb;
        repeat (16) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0;
        tb_drv = 1'b0; tb_wdata = '0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset txd", 32'(txd), 32'd1);
        check("reset dv", 32'(data_valid), 32'd0);
        reset = 1'b0;

        // reset-state LSR
        bus("T1 rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("T1 lsr", rd, 32'h60);
        check("T1 txd", 32'(txd), 32'd1);

        // single transmit frame
        bus("T2 wr thr", 1'b1, BASE, 8'h5A, rd);
        tx_frame("T2 5A", 8'h5A, 1'b1, waited);
        check("T2 latency", 32'(waited), 32'd0);
        bus("T2 rd lsr busy", 1'b0, BASE + 5, 8'h00, rd);
        check("T2 lsr busy", rd, 32'h20);
        repeat (5) @(negedge clk);
        bus("T2 rd lsr idle", 1'b0, BASE + 5, 8'h00, rd);
        check("T2 lsr idle", rd, 32'h60);

        // ignored writes and unmapped reads
        bus("T3 wr lsr", 1'b1, BASE + 5, 8'hA5, rd);
        bus("T3 rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("T3 lsr", rd, 32'h60);
        bus("T3 wr outside", 1'b1, BASE + 8, 8'h77, rd);
        bus("T3 rd lsr2", 1'b0, BASE + 5, 8'h00, rd);
        check("T3 lsr2", rd, 32'h60);
        check("T3 txd idle", 32'(txd), 32'd1);
        bus("T3 rd off3", 1'b0, BASE + 3, 8'h00, rd);
        check("T3 off3", rd, 32'h0);
        bus("T3 rd outside", 1'b0, BASE + 8, 8'h00, rd);
        check("T3 outside", rd, 32'h0);

        // single receive frame
        send_rx(8'h3C, 1'b1);
        bus("T4 rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("T4 lsr dr", rd, 32'h61);
        bus("T4 rd rbr", 1'b0, BASE, 8'h00, rd);
        check("T4 rbr", rd, 32'h3C);
        bus("T4 rd lsr2", 1'b0, BASE + 5, 8'h00, rd);
        check("T4 lsr clr", rd, 32'h60);

        // overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus("T5 rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("T5 lsr oe", rd, 32'h63);
        bus("T5 rd lsr2", 1'b0, BASE + 5, 8'h00, rd);
        check("T5 oe clr", rd, 32'h61);
        bus("T5 rd rbr", 1'b0, BASE, 8'h00, rd);
        check("T5 rbr", rd, 32'h22);
        bus("T5 rd lsr3", 1'b0, BASE + 5, 8'h00, rd);
        check("T5 lsr3", rd, 32'h60);

        // framing error: byte still stored
        send_rx(8'h55, 1'b0);
        bus("FE rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("FE lsr", rd, 32'h69);
        bus("FE rd lsr2", 1'b0, BASE + 5, 8'h00, rd);
        check("FE clr", rd, 32'h61);
        bus("FE rd rbr", 1'b0, BASE, 8'h00, rd);
        check("FE rbr", rd, 32'h55);

        // back-to-back writes, third dropped
        @(negedge clk);
        addr = BASE; we = 1'b1; req_valid = 1'b1; tb_drv = 1'b1; tb_wdata = 32'h41;
        @(negedge clk);
        tb_wdata = 32'h42;
        #1 check("T6 dv1", 32'(data_valid), 32'd1);
        @(negedge clk);
        tb_wdata = 32'h43;
        #1 check("T6 dv2", 32'(data_valid), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; we = 1'b0; tb_drv = 1'b0;
        #1 check("T6 dv3", 32'(data_valid), 32'd1);
        @(negedge clk);
        check("T6 dv low", 32'(data_valid), 32'd0);
        tx_frame("T6 41", 8'h41, 1'b1, waited);
        tx_frame("T6 42", 8'h42, 1'b0, waited);
        repeat (8) @(negedge clk);
        bus("T6 rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("T6 lsr", rd, 32'h60);
        zeros = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        check("T6 no third frame", 32'(zeros), 32'd0);

        // reset mid-frame
        bus("R wr thr", 1'b1, BASE, 8'h00, rd);
        repeat (30) @(negedge clk);
        check("R txd mid", 32'(txd), 32'd0);
        #2 reset = 1'b1;
        #1 check("R txd reset", 32'(txd), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus("R rd lsr", 1'b0, BASE + 5, 8'h00, rd);
        check("R lsr", rd, 32'h60);
        zeros = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1) zeros++;
        end
        check("R txd idle", 32'(zeros), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
